imem_arbiter: RTL and testbench

Shares one synchronous-read instruction memory port between the CPU fetch path and a data-side read path; the data-side path serves PC-relative literal loads and debug reads. Round-robin arbitration on conflict, one access per cycle. Each read response returns exactly one cycle after grant. A branch flush cancels an in-flight fetch response. Sits between the fetch/memory stages and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 25 ++
 rtl/imem_arbiter_rr_arb2.sv | 39 +++
 rtl/imem_arbiter.sv | 101 ++++++++++
 tb/tb_imem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: owner_t in-flight owner encoding, default widths, word_align helper.
package imem_arb_pkg;

   localparam int unsigned IMEM_ADDR_W = 32;
   localparam int unsigned IMEM_DATA_W = 32;

   // Requester index used on the two-bit req/gnt vectors of rr_arb2.
   localparam int unsigned REQ_FETCH = 0;
   localparam int unsigned REQ_DATA  = 1;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   // Clears the byte offset within a 32-bit word. Callers cast to their width.
   function automatic logic [63:0] word_align(input logic [63:0] addr);
      return addr & ~64'h3;
   endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the loser of a conflict wins the next one.
// Latency: 0 cycles, grant is combinational from req.
// Backpressure: a requester not granted simply sees gnt low and retries.
// Ports: clk, reset (async, active high), req[1:0] in, gnt[1:0] out (one-hot or 0),
//        conflict out (both requesting this cycle).
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       conflict
);

   // Index of the requester that won the most recent conflict.
   // Resets to 1 so requester 0 wins the first conflict.
   logic rr_last;

   always_comb begin
      gnt      = 2'b00;
      conflict = 1'b0;
      if (!reset) begin
         conflict = req[0] & req[1];
         if (conflict) begin
            gnt = rr_last ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last <= 1'b1;
      end else if (conflict) begin
         rr_last <= gnt[1];
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one synchronous-read instruction memory port between fetch and data-side reads.
// Latency: grant same cycle as request, read data valid exactly one cycle after grant.
// Backpressure: losing/flushed requester sees gnt low and must hold req/addr; no queuing.
// Ports: clk, reset (async, active high); fetch f_req/f_addr/f_gnt/f_rvalid/f_rdata;
//        data d_req/d_addr/d_gnt/d_rvalid/d_rdata; flush; memory mem_en/mem_addr/mem_rdata;
//        conflict_cnt (saturating count of cycles where both sides requested).
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              flush,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              conflict;
   logic [ADDR_W-1:0] sel_addr;
   owner_t            owner;
   owner_t            owner_d;

   // A flushed fetch is invisible to the arbiter, so the data side is
   // arbitrated alone and the cycle is not a conflict.
   assign req[REQ_FETCH] = f_req & ~flush;
   assign req[REQ_DATA]  = d_req;

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .gnt      (gnt),
      .conflict (conflict)
   );

   assign f_gnt  = gnt[REQ_FETCH];
   assign d_gnt  = gnt[REQ_DATA];
   assign mem_en = f_gnt | d_gnt;

   always_comb begin
      sel_addr = '0;
      if (f_gnt) begin
         sel_addr = f_addr;
      end else if (d_gnt) begin
         sel_addr = d_addr;
      end
   end

   // sel_addr is zero when idle, so mem_addr is zero too.
   assign mem_addr = ADDR_W'(word_align(64'(sel_addr)));

   // Owner of the read currently in flight in the memory pipeline.
   always_comb begin
      owner_d = OWN_NONE;
      if (f_gnt) begin
         owner_d = OWN_FETCH;
      end else if (d_gnt) begin
         owner_d = OWN_DATA;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_d;
      end
   end

   // A flush in the cycle the fetch data returns kills that response.
   assign f_rvalid = (owner == OWN_FETCH) & ~flush;
   assign d_rvalid = (owner == OWN_DATA);
   assign f_rdata  = f_rvalid ? mem_rdata : '0;
   assign d_rdata  = d_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (conflict && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus constrained-random
// traffic, all checked against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int          CNT_MAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req, d_req, flush;
   logic [AW-1:0] f_addr, d_addr;
   logic          f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en;
   logic [DW-1:0] f_rdata, d_rdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] conflict_cnt;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .f_req        (f_req),
      .f_addr       (f_addr),
      .f_gnt        (f_gnt),
      .f_rvalid     (f_rvalid),
      .f_rdata      (f_rdata),
      .d_req        (d_req),
      .d_addr       (d_addr),
      .d_gnt        (d_gnt),
      .d_rvalid     (d_rvalid),
      .d_rdata      (d_rdata),
      .flush        (flush),
      .mem_en       (mem_en),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (conflict_cnt)
   );

   // Synchronous-read instruction memory, 256 words.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem[mem_addr[9:2]];
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state. Requester codes: 0 none, 1 fetch, 2 data.
   int          m_last;   // winner of the last conflict
   int          m_cnt;
   int          m_pend;   // whose read returns next cycle
   logic [31:0] m_paddr;
   int          m_win;

   // Values sampled in the most recent step, for directed checks.
   logic        s_fgnt, s_dgnt, s_frv, s_drv;
   logic [31:0] s_frd, s_maddr;
   int          s_cnt;

   task automatic model_reset();
      m_last  = 2;
      m_cnt   = 0;
      m_pend  = 0;
      m_paddr = 32'h0;
      m_win   = 0;
   endtask

   // Called at posedge+1: drive one cycle of inputs, check, advance to next posedge+1.
   task automatic step(input bit fr, input logic [31:0] fa, input bit dr,
                       input logic [31:0] da, input bit fl);
      bit          fe, frv_e, drv_e;
      int          win;
      logic [31:0] waddr;
      f_req  = fr;
      f_addr = fa;
      d_req  = dr;
      d_addr = da;
      flush  = fl;
      #3;
      fe = fr && !fl;
      if (fe && dr)  win = (m_last == 2) ? 1 : 2;
      else if (fe)   win = 1;
      else if (dr)   win = 2;
      else           win = 0;
      waddr = (win == 1) ? fa : (win == 2) ? da : 32'h0;
      frv_e = (m_pend == 1) && !fl;
      drv_e = (m_pend == 2);
      s_fgnt = f_gnt;  s_dgnt = d_gnt;  s_frv = f_rvalid;  s_drv = d_rvalid;
      s_frd = f_rdata; s_maddr = mem_addr; s_cnt = int'(conflict_cnt);
      check("f_gnt",    64'(f_gnt),    64'(win == 1));
      check("d_gnt",    64'(d_gnt),    64'(win == 2));
      check("mem_en",   64'(mem_en),   64'(win != 0));
      check("mem_addr", 64'(mem_addr), 64'(waddr & ~32'h3));
      check("f_rvalid", 64'(f_rvalid), 64'(frv_e));
      check("d_rvalid", 64'(d_rvalid), 64'(drv_e));
      check("f_rdata",  64'(f_rdata),  frv_e ? 64'(mem[m_paddr[9:2]]) : 64'h0);
      check("d_rdata",  64'(d_rdata),  drv_e ? 64'(mem[m_paddr[9:2]]) : 64'h0);
      check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      if (fe && dr) begin
         m_last = win;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_pend  = win;
      m_paddr = waddr;
      m_win   = win;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_f_gnt"},    64'(f_gnt),    64'h0);
      check({tag, "_d_gnt"},    64'(d_gnt),    64'h0);
      check({tag, "_mem_en"},   64'(mem_en),   64'h0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
      check({tag, "_f_rvalid"}, 64'(f_rvalid), 64'h0);
      check({tag, "_d_rvalid"}, 64'(d_rvalid), 64'h0);
      check({tag, "_d_rdata"},  64'(d_rdata),  64'h0);
      check({tag, "_cnt"},      64'(conflict_cnt), 64'h0);
   endtask

   bit          fp, dp;
   logic [31:0] ra_f, ra_d;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[2] = 32'hE2437009;
      reset  = 1'b1;
      f_req  = 1'b1;
      d_req  = 1'b1;
      f_addr = 32'h1234;
      d_addr = 32'h5678;
      flush  = 1'b0;
      #2;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      // Fetch only.
      step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
      check("t1_maddr", 64'(s_maddr), 64'h8);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("t1_frv",   64'(s_frv), 64'h1);
      check("t1_frdata", 64'(s_frd), 64'hE2437009);
      check("t1_drv",   64'(s_drv), 64'h0);

      // Conflict alternation: F, D, F, D.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'h200 + 32'(4 * i), 1'b0);
         check("alt_fgnt", 64'(s_fgnt), 64'((i % 2) == 0));
         check("alt_dgnt", 64'(s_dgnt), 64'((i % 2) == 1));
      end
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("alt_cnt", 64'(s_cnt), 64'd4);
      check("alt_drv", 64'(s_drv), 64'h1);

      // Misaligned data address.
      step(1'b0, 32'h0, 1'b1, 32'h47, 1'b0);
      check("mis_maddr", 64'(s_maddr), 64'h44);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("mis_drv", 64'(s_drv), 64'h1);

      // Flush kills the fetch response and the fetch grant, data proceeds.
      step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
      check("fl_frv",  64'(s_frv),  64'h0);
      check("fl_fgnt", 64'(s_fgnt), 64'h0);
      check("fl_dgnt", 64'(s_dgnt), 64'h1);
      step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
      check("fl_cnt",   64'(s_cnt),  64'd4);
      check("fl_fgnt2", 64'(s_fgnt), 64'h1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Reset while a data read is in flight.
      step(1'b0, 32'h0, 1'b1, 32'h30, 1'b0);
      reset = 1'b1;
      f_req = 1'b1;
      d_req = 1'b1;
      #3;
      check_reset_outputs("rmid");
      @(posedge clk);
      #1;
      check("rmid_drv2", 64'(d_rvalid), 64'h0);
      reset = 1'b0;
      model_reset();
      step(1'b1, 32'h40, 1'b1, 32'h50, 1'b0);
      check("rmid_fgnt", 64'(s_fgnt), 64'h1);
      check("rmid_drv3", 64'(s_drv),  64'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Saturation of the 4-bit counter.
      for (int i = 0; i < 20; i++) step(1'b1, 32'h60, 1'b1, 32'h64, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("sat_cnt", 64'(s_cnt), 64'd15);

      // Random traffic with hold-until-granted requesters.
      reset = 1'b1;
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      fp = 1'b0;
      dp = 1'b0;
      ra_f = 32'h0;
      ra_d = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (!fp) begin
            fp   = ($urandom_range(0, 3) != 0);
            ra_f = 32'($urandom_range(0, 1023));
         end
         if (!dp) begin
            dp   = ($urandom_range(0, 2) == 0);
            ra_d = 32'($urandom_range(0, 1023));
         end
         step(fp, ra_f, dp, ra_d, ($urandom_range(0, 7) == 0));
         if (m_win == 1) fp = 1'b0;
         if (m_win == 2) dp = 1'b0;
      end
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
